icache_responder: RTL and testbench

Instruction-side memory responder serving the fetch stage's address/instruction interface. Each cycle it receives the fetch address and returns the 32-bit instruction in the same cycle on a hit from a direct-mapped cache of 4-word lines. On a miss it asserts a stall, which the fetch stage consumes as `no_new_fetch`, and refills the line from a backing memory over a request/acknowledge handshake with a 4-beat data burst.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_array.sv | 61 ++++++
 rtl/icache_responder.sv | 134 +++++++++++++
 tb/tb_icache_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state enum, line geometry, NOP encoding, index/tag width helpers.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  localparam int          WORDS_PER_LINE = 4;
  localparam int          OFFSET_BITS    = 4;
  localparam logic [31:0] NOP            = 32'h0000_0000;

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines);
    return 32 - OFFSET_BITS - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage of a direct-mapped cache with 4-word lines.
// Latency: combinational read; word, tag and valid writes land at the clock edge.
// Backpressure: none; every write strobe is taken in the cycle it is presented.
// Ports: i_clk/i_rst (sync, active-high, clears valid only); read port i_rd_*/o_rd_*;
//        word write i_wr_*; tag+valid write i_tag_*; single-line invalidate i_inv_*;
//        i_clr_all drops every valid bit in one cycle.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX   = idx_width(LINES),
  parameter int TAG   = tag_width(LINES)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [IDX-1:0] i_rd_idx,
  input  logic [1:0]     i_rd_word,
  output logic           o_rd_vld,
  output logic [TAG-1:0] o_rd_tag,
  output logic [31:0]    o_rd_dat,
  input  logic           i_wr_en,
  input  logic [IDX-1:0] i_wr_idx,
  input  logic [1:0]     i_wr_word,
  input  logic [31:0]    i_wr_dat,
  input  logic           i_tag_we,
  input  logic [IDX-1:0] i_tag_idx,
  input  logic [TAG-1:0] i_tag,
  input  logic           i_set_vld,
  input  logic           i_inv_en,
  input  logic [IDX-1:0] i_inv_idx,
  input  logic           i_clr_all
);

  logic [LINES-1:0] r_valid;
  logic [TAG-1:0]   r_tag  [LINES];
  logic [31:0]      r_data [LINES][WORDS_PER_LINE];

  assign o_rd_vld = r_valid[i_rd_idx];
  assign o_rd_tag = r_tag[i_rd_idx];
  assign o_rd_dat = r_data[i_rd_idx][i_rd_word];

  // A global clear wins over any per-line update in the same cycle, so a
  // line completing together with a flush is never left valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_clr_all) begin
      r_valid <= '0;
    end else begin
      if (i_inv_en) r_valid[i_inv_idx] <= 1'b0;
      if (i_tag_we) r_valid[i_tag_idx] <= i_set_vld;
    end
  end

  // Tag and data contents are don't-care until their valid bit is set.
  always_ff @(posedge i_clk) begin
    if (i_tag_we) r_tag[i_tag_idx] <= i_tag;
    if (i_wr_en)  r_data[i_wr_idx][i_wr_word] <= i_wr_dat;
  end

endmodule

// File: rtl/icache_responder.sv
// Instruction-side responder: same-cycle hit from a direct-mapped cache, refill on miss.
// Latency: hit returns in the address cycle; minimum miss penalty is 6 cycles.
// Backpressure: ic_stall holds fetch during a miss; memory paced by mem_ack and mem_rvalid.
// Ports: CLK/RESET (sync, active-high); fetch side Instr_address_2IM, fetch_valid, flush,
//        Instr1_fIM, ic_hit, ic_stall; memory side mem_req, mem_addr, mem_ack,
//        mem_rvalid, mem_rdata (4 beats per line, word order 0..3).
module icache_responder
  import icache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_address_2IM,
  input  logic        fetch_valid,
  input  logic        flush,
  output logic [31:0] Instr1_fIM,
  output logic        ic_hit,
  output logic        ic_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int IDX = idx_width(LINES);
  localparam int TAG = tag_width(LINES);

  state_e         r_state;
  state_e         w_state_nxt;
  logic [31:0]    r_mem_addr;
  logic [1:0]     r_beat;
  logic           r_flush_pend;

  logic [IDX-1:0] w_idx;
  logic [TAG-1:0] w_tag;
  logic [1:0]     w_word;
  logic [IDX-1:0] w_fill_idx;
  logic [TAG-1:0] w_fill_tag;
  logic           w_arr_vld;
  logic [TAG-1:0] w_arr_tag;
  logic [31:0]    w_arr_dat;
  logic           w_hit;
  logic           w_miss;
  logic           w_beat_we;
  logic           w_last_beat;
  logic           w_unused_addr_lsb;

  assign w_word = Instr_address_2IM[3:2];
  assign w_idx  = Instr_address_2IM[OFFSET_BITS+IDX-1:OFFSET_BITS];
  assign w_tag  = Instr_address_2IM[31:OFFSET_BITS+IDX];

  // Byte offset within a word plays no part in instruction lookup.
  assign w_unused_addr_lsb = ^Instr_address_2IM[1:0];

  // The fill target comes from the latched line address, not the live fetch
  // address, so a redirect during REQ/FILL cannot steer the refill.
  assign w_fill_idx = r_mem_addr[OFFSET_BITS+IDX-1:OFFSET_BITS];
  assign w_fill_tag = r_mem_addr[31:OFFSET_BITS+IDX];

  assign w_miss      = (r_state == ST_IDLE) && fetch_valid && !w_hit;
  assign w_beat_we   = (r_state == ST_FILL) && mem_rvalid;
  assign w_last_beat = w_beat_we && (r_beat == 2'd3);

  icache_array #(
    .LINES (LINES),
    .IDX   (IDX),
    .TAG   (TAG)
  ) u_array (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_rd_idx  (w_idx),
    .i_rd_word (w_word),
    .o_rd_vld  (w_arr_vld),
    .o_rd_tag  (w_arr_tag),
    .o_rd_dat  (w_arr_dat),
    .i_wr_en   (w_beat_we),
    .i_wr_idx  (w_fill_idx),
    .i_wr_word (r_beat),
    .i_wr_dat  (mem_rdata),
    .i_tag_we  (w_last_beat),
    .i_tag_idx (w_fill_idx),
    .i_tag     (w_fill_tag),
    .i_set_vld (!r_flush_pend && !flush),
    .i_inv_en  (w_miss),
    .i_inv_idx (w_idx),
    .i_clr_all (flush)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_miss)      w_state_nxt = ST_REQ;
      ST_REQ:  if (mem_ack)     w_state_nxt = ST_FILL;
      ST_FILL: if (w_last_beat) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_hit      = fetch_valid && (r_state == ST_IDLE) && w_arr_vld && (w_arr_tag == w_tag);
    ic_hit     = w_hit;
    ic_stall   = fetch_valid && !w_hit;
    Instr1_fIM = w_hit ? w_arr_dat : NOP;
    mem_req    = (r_state == ST_REQ);
    mem_addr   = r_mem_addr;
  end

  // Miss address latch, beat counter and flush-pending flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mem_addr   <= '0;
      r_beat       <= 2'd0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_miss) r_mem_addr <= {Instr_address_2IM[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      if (w_beat_we) r_beat <= r_beat + 2'd1;
      // Completion clears the flag even if a flush lands on the final beat:
      // that flush already drops the line via the array's global clear.
      if (w_last_beat)                        r_flush_pend <= 1'b0;
      else if (flush && r_state != ST_IDLE)   r_flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;

  localparam int LINES = 64;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr_address_2IM;
  logic        fetch_valid;
  logic        flush;
  logic [31:0] Instr1_fIM;
  logic        ic_hit;
  logic        ic_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  icache_responder #(.LINES(LINES)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Instr_address_2IM (Instr_address_2IM),
    .fetch_valid       (fetch_valid),
    .flush             (flush),
    .Instr1_fIM        (Instr1_fIM),
    .ic_hit            (ic_hit),
    .ic_stall          (ic_stall),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_ack           (mem_ack),
    .mem_rvalid        (mem_rvalid),
    .mem_rdata         (mem_rdata)
  );

  // Backing memory contents: line 0x100 holds 0xA0..0xA3, every other word distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_00A0 + ((a - 32'h0000_0100) >> 2);
  endfunction

  // Miss cycle (cycle 0): drive the address, expect stall and no hit.
  task automatic start_miss(input string nm, input logic [31:0] a, input bit push);
    @(negedge CLK);
    RESET = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
    fetch_valid = 1'b1; Instr_address_2IM = a;
    if (push) exp_q.push_back(mem_word(a));
    #1;
    n_checks++; if (ic_stall !== 1'b1) $display("FAIL %s miss_stall: got %b want 1", nm, ic_stall); else n_pass++;
    n_checks++; if (ic_hit !== 1'b0) $display("FAIL %s miss_hit: got %b want 0", nm, ic_hit); else n_pass++;
    n_checks++; if (Instr1_fIM !== 32'h0) $display("FAIL %s miss_nop: got %h want 0", nm, Instr1_fIM); else n_pass++;
  endtask

  // REQ (with optional ack delay) then four FILL beats; flush on beat flush_beat (-1: none).
  task automatic serve_fill(input string nm, input logic [31:0] a, input int ack_delay, input int flush_beat);
    logic [31:0] line;
    line = {a[31:4], 4'h0};
    for (int c = 0; c < ack_delay; c++) begin
      @(negedge CLK); mem_ack = 1'b0; #1;
      n_checks++; if (mem_req !== 1'b1) $display("FAIL %s req_wait%0d: got %b want 1", nm, c, mem_req); else n_pass++;
      n_checks++; if (ic_stall !== 1'b1) $display("FAIL %s stall_wait%0d: got %b want 1", nm, c, ic_stall); else n_pass++;
    end
    @(negedge CLK); mem_ack = 1'b1; #1;
    n_checks++; if (mem_req !== 1'b1) $display("FAIL %s req: got %b want 1", nm, mem_req); else n_pass++;
    n_checks++; if (mem_addr !== line) $display("FAIL %s mem_addr: got %h want %h", nm, mem_addr, line); else n_pass++;
    n_checks++; if (ic_stall !== 1'b1) $display("FAIL %s stall_req: got %b want 1", nm, ic_stall); else n_pass++;
    for (int b = 0; b < 4; b++) begin
      @(negedge CLK);
      mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = mem_word(line + 32'(4 * b));
      flush = (b == flush_beat);
      #1;
      n_checks++; if (mem_req !== 1'b0) $display("FAIL %s req_fill%0d: got %b want 0", nm, b, mem_req); else n_pass++;
      n_checks++; if (ic_stall !== 1'b1) $display("FAIL %s stall_fill%0d: got %b want 1", nm, b, ic_stall); else n_pass++;
    end
  endtask

  // Cycle after the last beat: back in IDLE, expect a hit with the queued word.
  task automatic finish_hit(input string nm);
    logic [31:0] exp;
    @(negedge CLK);
    mem_rvalid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    #1;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    n_checks++; if (ic_hit !== 1'b1 || ic_stall !== 1'b0) $display("FAIL %s fill_hit: got hit=%b stall=%b want 1/0", nm, ic_hit, ic_stall); else n_pass++;
    n_checks++; if (Instr1_fIM !== exp) $display("FAIL %s fill_instr: got %h want %h", nm, Instr1_fIM, exp); else n_pass++;
  endtask

  task automatic fetch_hit(input string nm, input logic [31:0] a);
    logic [31:0] exp;
    @(negedge CLK);
    fetch_valid = 1'b1; Instr_address_2IM = a; flush = 1'b0;
    exp_q.push_back(mem_word(a));
    #1;
    exp = exp_q.pop_front();
    n_checks++; if (ic_hit !== 1'b1 || ic_stall !== 1'b0) $display("FAIL %s hit: got hit=%b stall=%b want 1/0", nm, ic_hit, ic_stall); else n_pass++;
    n_checks++; if (Instr1_fIM !== exp) $display("FAIL %s instr: got %h want %h", nm, Instr1_fIM, exp); else n_pass++;
  endtask

  task automatic test_reset();
    RESET = 1'b1; fetch_valid = 1'b0; flush = 1'b0; Instr_address_2IM = 32'h0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset mem_req: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset mem_addr: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (ic_hit !== 1'b0 || ic_stall !== 1'b0) $display("FAIL reset hit_stall: got %b/%b want 0/0", ic_hit, ic_stall); else n_pass++;
    n_checks++; if (Instr1_fIM !== 32'h0) $display("FAIL reset instr: got %h want 0", Instr1_fIM); else n_pass++;
  endtask

  task automatic test_miss_fill();
    start_miss("first", 32'h0000_0100, 1'b1);
    serve_fill("first", 32'h0000_0100, 0, -1);
    finish_hit("first");
  endtask

  task automatic test_hits();
    fetch_hit("hit104", 32'h0000_0104);
    fetch_hit("hit108", 32'h0000_0108);
    fetch_hit("hit10c", 32'h0000_010C);
  endtask

  task automatic test_conflict();
    start_miss("conflict", 32'h0000_0100 + LINES * 16, 1'b1);
    serve_fill("conflict", 32'h0000_0100 + LINES * 16, 0, -1);
    finish_hit("conflict");
    start_miss("evicted", 32'h0000_0100, 1'b1);
    serve_fill("evicted", 32'h0000_0100, 0, -1);
    finish_hit("evicted");
  endtask

  task automatic test_flush();
    start_miss("flush_fill", 32'h0000_0200, 1'b1);
    serve_fill("flush_fill", 32'h0000_0200, 0, 2);
    // Fill completed but left invalid: the same address misses on return to IDLE.
    @(negedge CLK); mem_rvalid = 1'b0; flush = 1'b0; #1;
    n_checks++; if (ic_stall !== 1'b1 || ic_hit !== 1'b0) $display("FAIL flush_fill remiss: got stall=%b hit=%b want 1/0", ic_stall, ic_hit); else n_pass++;
    serve_fill("flush_refill", 32'h0000_0200, 0, -1);
    finish_hit("flush_refill");
    // Flush in IDLE drops the freshly filled line.
    @(negedge CLK); fetch_valid = 1'b0; flush = 1'b1;
    start_miss("flush_idle", 32'h0000_0204, 1'b1);
    serve_fill("flush_idle", 32'h0000_0204, 0, -1);
    finish_hit("flush_idle");
  endtask

  task automatic test_reset_mid_fill();
    start_miss("rst_fill", 32'h0000_0300, 1'b1);
    @(negedge CLK); mem_ack = 1'b1;
    @(negedge CLK); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = mem_word(32'h0000_0300);
    @(negedge CLK); mem_rdata = mem_word(32'h0000_0304); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0; fetch_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_fill mem_req: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL rst_fill mem_addr: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (ic_stall !== 1'b0 || Instr1_fIM !== 32'h0) $display("FAIL rst_fill idle_out: got stall=%b instr=%h want 0/0", ic_stall, Instr1_fIM); else n_pass++;
    @(negedge CLK); mem_rvalid = 1'b0; fetch_valid = 1'b1; Instr_address_2IM = 32'h0000_0300; #1;
    n_checks++; if (ic_stall !== 1'b1 || mem_req !== 1'b0) $display("FAIL rst_fill remiss: got stall=%b req=%b want 1/0", ic_stall, mem_req); else n_pass++;
    serve_fill("rst_refill", 32'h0000_0300, 0, -1);
    finish_hit("rst_refill");
  endtask

  task automatic test_ack_delay();
    start_miss("ack_delay", 32'h0000_0400, 1'b1);
    serve_fill("ack_delay", 32'h0000_0400, 5, -1);
    finish_hit("ack_delay");
    @(negedge CLK); fetch_valid = 1'b0; #1;
    n_checks++; if (ic_stall !== 1'b0 || ic_hit !== 1'b0) $display("FAIL no_fetch hit_stall: got %b/%b want 0/0", ic_hit, ic_stall); else n_pass++;
    n_checks++; if (Instr1_fIM !== 32'h0) $display("FAIL no_fetch instr: got %h want 0", Instr1_fIM); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL no_fetch mem_req: got %b want 0", mem_req); else n_pass++;
  endtask

  task automatic test_back_to_back();
    start_miss("b2b_a", 32'h0000_0800, 1'b0);
    serve_fill("b2b_a", 32'h0000_0800, 0, -1);
    // The cycle the FSM returns to IDLE is itself the next miss cycle.
    start_miss("b2b_b", 32'h0000_0904, 1'b1);
    serve_fill("b2b_b", 32'h0000_0904, 0, -1);
    finish_hit("b2b_b");
    fetch_hit("b2b_a_hit", 32'h0000_0808);
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hits();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_ack_delay();
    test_back_to_back();
    n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
